tns_encoder_param: RTL and testbench
====================================

// Module: tns_encoder_param
// PURPOSE
//  Streaming parametrised TNS crosstalk-avoidance encoder.
//  - Maps a binary word onto NGROUPS 3-wire groups (base-5 digit per group).
//  - Resolves the ambiguous digit from per-group history to minimise top-wire toggles.
//  - Sits between the bus-side data source and the 3C1S wire driver.
//  - Adds valid/ready flow control and a registered output to the fixed 2-group encoder.
// PARAMETERS
//  NGROUPS  2                     number of 3-wire groups; legal range 1..8
//  DW       clog2(5**NGROUPS)     localparam: input width (2->5, 3->7, 4->10)
//  CW       3*NGROUPS             localparam: codeword width
// PORTS
//  clock      in   1    rising-edge clock
//  reset_n    in   1    asynchronous active-low reset
//  in_data    in   DW   binary value, legal range 0..5**NGROUPS-1
//  in_valid   in   1    in_data is valid
//  in_ready   out  1    encoder accepts in_data this cycle
//  out_code   out  CW   codeword; group k occupies bits [3k+2:3k]
//  out_valid  out  1    out_code/out_err are valid
//  out_ready  in   1    sink accepts out_code this cycle
//  out_err    out  1    the word in the output register was out of range
// BEHAVIOUR
//  - Reset (async assert, sync release): out_code=0, out_valid=0, out_err=0, all history bits h[k]=0.
//  - Handshake: in_ready = !out_valid || out_ready, combinational, with no skid buffer.
//    * Accept when in_valid && in_ready; the output register loads at that edge.
//    * Latency is 1 cycle; throughput is 1 word per clock.
//    * If out_valid && !out_ready, out_code and out_err are held stable.
//    * Simultaneous pop and push: the new word replaces the old word in the same edge.
//  - Digit extraction, MSB group first, by successive compare/subtract.
//    * Group k weights: A=2*5^k, B=5^k, C=5^k.
//    * Group 0 has no C-subtract; its last bit is the 1-bit remainder.
//  - Group bits b2 b1 b0 = [3k+2:3k]:
//    * r <  A         -> b2=0
//    * r >= A+C       -> b2=1
//    * A <= r < A+C   -> b2 = h[k]
//    * b1 = (r-b2*A) >= B
//    * b0 = remainder >= C; for group 0, b0 is the remainder itself.
//  - Digit-to-codeword map, per group:
//    0->000, 1->010, 2->(h?100:011), 3->110, 4->111.
//  - History: h[k] <= b2 of group k.
//    * Updates only on an accepted, in-range word.
//    * A stalled output or an idle cycle leaves history unchanged.
//  - Out of range (in_data >= 5**NGROUPS):
//    * The word is still accepted.
//    * out_err=1 and out_code = previous out_code.
//    * History is unchanged.
//  - Reset asserted mid-stream drops any pending output word and clears history immediately.
// CONFIGURATION
//  TNS_ENC_ERRCNT_EN
//    * Defined: adds port err_cnt (out, 16 bits).
//      Saturating count of accepted out-of-range words; reset 0; holds at 16'hFFFF.
//    * Undefined: the port is absent. out_err behaviour is identical in both builds.
// STRUCTURE
//  - Shared header TNS.vh holds:
//    * the per-group weight macros/function (A, B, C as multiples of 5^k);
//    * the clog2 function;
//    * the group width constant (3).
//  - Sub-module tns_group_enc (combinational, one per group, generate loop):
//    * inputs: remainder, h, weights;
//    * outputs: 3 code bits, next remainder, ambiguous flag.
//  - Top level holds the handshake, output register, history register and range check.
// TESTING (NGROUPS=2, DW=5, CW=6)
//  1. Reset, then push 12 -> 1 cycle later out_code=6'b011_011, out_valid=1, out_err=0.
//  2. Push 22 then 12 back-to-back with out_ready=1 -> outputs 6'b111_011, then 6'b100_011.
//     Group 1 resolves with h=1 from the 22.
//  3. Push 24 with out_ready=0 for 3 cycles:
//     - out_code=6'b111_111 is held stable and in_ready=0;
//     - a second word pushed while stalled is not accepted;
//     - history is unchanged until out_ready=1.
//  4. Push 25 -> out_err=1, out_code=previous word; then push 12 -> 6'b011_011.
//     History is unaffected; with TNS_ENC_ERRCNT_EN, err_cnt=1.
//  5. Sweep 0..24 from reset and decode each codeword -> every value round-trips.
//     Group top wire toggles only when the digit forces it.
//  6. Assert reset_n=0 while out_valid=1 and out_ready=0:
//     - out_valid=0 and out_code=0 immediately;
//     - after release, push 2 -> 6'b000_011.

Source files
------------

// File: rtl/tns_encoder_param_pkg.sv
// Shared constants and constant functions for the TNS crosstalk-avoidance encoder.
//   GroupW          : wires per group (3)
//   tns_pow5(k)     : 5^k
//   tns_clog2(v)    : ceil(log2(v)), used to size the binary input
//   tns_weight_*(k) : per-group compare/subtract weights A=2*5^k, B=5^k, C=5^k
package tns_encoder_param_pkg;

    localparam int unsigned GroupW = 3;

    // Raw 3-wire pattern for one group, bit order {b2, b1, b0}.
    typedef logic [GroupW-1:0] group_code_t;

    function automatic int unsigned tns_pow5(input int unsigned k);
        int unsigned res;
        res = 1;
        for (int unsigned i = 0; i < k; i++) begin
            res = res * 5;
        end
        return res;
    endfunction

    function automatic int unsigned tns_clog2(input int unsigned v);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(v)) begin
            res++;
        end
        return res;
    endfunction

    function automatic int unsigned tns_weight_a(input int unsigned k);
        return 2 * tns_pow5(k);
    endfunction

    function automatic int unsigned tns_weight_b(input int unsigned k);
        return tns_pow5(k);
    endfunction

    function automatic int unsigned tns_weight_c(input int unsigned k);
        return tns_pow5(k);
    endfunction

endpackage

// File: rtl/tns_encoder_param_group_enc.sv
// One 3-wire TNS group: peels the base-5 digit of this group off the running
// remainder by compare/subtract and emits the group codeword.
// Ports:
//   rem_i   : remainder entering this group (higher groups already removed)
//   hist_i  : last top-wire value of this group, resolves digit 2
//   wa_i    : weight A = 2*5^k
//   wb_i    : weight B = 5^k
//   wc_i    : weight C = 5^k
//   code_o  : {b2, b1, b0} for this group
//   rem_o   : remainder passed to the next lower group
//   ambig_o : digit is 2, so b2 came from history
module tns_encoder_param_group_enc
    import tns_encoder_param_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] rem_i,
    input  logic         hist_i,
    input  logic [W-1:0] wa_i,
    input  logic [W-1:0] wb_i,
    input  logic [W-1:0] wc_i,
    output group_code_t  code_o,
    output logic [W-1:0] rem_o,
    output logic         ambig_o
);

    logic         lo_a;
    logic         hi_ac;
    logic         b2;
    logic         b1;
    logic         b0;
    logic [W-1:0] r1;
    logic [W-1:0] r2;

    always_comb begin
        lo_a    = rem_i < wa_i;
        hi_ac   = rem_i >= (wa_i + wc_i);
        ambig_o = !lo_a && !hi_ac;
        // Digit 2 can be sent as 011 or 100; keep the top wire where it was.
        b2      = hi_ac || (ambig_o && hist_i);
        r1      = b2 ? (rem_i - wa_i) : rem_i;
        b1      = r1 >= wb_i;
        r2      = b1 ? (r1 - wb_i) : r1;
        // For group 0 (C=1) r2 is 0 or 1 here, so b0 is just that bit.
        b0      = r2 >= wc_i;
        rem_o   = b0 ? (r2 - wc_i) : r2;
        code_o  = {b2, b1, b0};
    end

endmodule

// File: rtl/tns_encoder_param.sv
// Streaming parametrised TNS crosstalk-avoidance encoder with valid/ready flow
// control and a registered output. Maps a binary word onto NGROUPS 3-wire groups
// (one base-5 digit each); the ambiguous digit 2 is resolved from per-group
// history so the top wire of a group only toggles when the digit forces it.
// Ports:
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   in_data   : binary value, legal 0..5**NGROUPS-1
//   in_valid  : in_data valid
//   in_ready  : word accepted this cycle (!out_valid || out_ready)
//   out_code  : codeword, group k at [3k+2:3k]
//   out_valid : out_code/out_err valid
//   out_ready : sink takes out_code this cycle
//   out_err   : word in the output register was out of range
//   err_cnt   : saturating count of accepted out-of-range words
//               (present only when TNS_ENC_ERRCNT_EN is defined)
// NGROUPS legal range is 1..8.
module tns_encoder_param
    import tns_encoder_param_pkg::*;
#(
    parameter  int unsigned NGROUPS = 2,
    localparam int unsigned DW      = tns_clog2(tns_pow5(NGROUPS)),
    localparam int unsigned CW      = GroupW * NGROUPS
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [CW-1:0] out_code,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef TNS_ENC_ERRCNT_EN
    output logic [15:0]   err_cnt,
`endif
    output logic          out_err
);

    localparam logic [DW-1:0] Limit = DW'(tns_pow5(NGROUPS));

    logic               accept;
    logic               in_range;
    logic [DW-1:0]      rem [NGROUPS+1];
    logic [CW-1:0]      code_next;
    logic [NGROUPS-1:0] ambig;
    logic [NGROUPS-1:0] hist_new;

    logic [CW-1:0]      code_d, code_q;
    logic               valid_d, valid_q;
    logic               err_d, err_q;
    logic [NGROUPS-1:0] hist_d, hist_q;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign in_range = in_data < Limit;

    // Digit extraction runs MSB group first; each group hands its remainder down.
    assign rem[NGROUPS] = in_data;

    for (genvar k = 0; k < NGROUPS; k++) begin : gen_group
        localparam logic [DW-1:0] WeightA = DW'(tns_weight_a(k));
        localparam logic [DW-1:0] WeightB = DW'(tns_weight_b(k));
        localparam logic [DW-1:0] WeightC = DW'(tns_weight_c(k));

        tns_encoder_param_group_enc #(
            .W(DW)
        ) u_group_enc (
            .rem_i   (rem[k+1]),
            .hist_i  (hist_q[k]),
            .wa_i    (WeightA),
            .wb_i    (WeightB),
            .wc_i    (WeightC),
            .code_o  (code_next[GroupW*k +: GroupW]),
            .rem_o   (rem[k]),
            .ambig_o (ambig[k])
        );

        assign hist_new[k] = code_next[GroupW*k + 2];
    end

    // Final remainder is always zero and the ambiguity flags are diagnostic only.
    logic unused_tail;
    assign unused_tail = ^{rem[0], ambig};

    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        err_d   = err_q;
        hist_d  = hist_q;
        if (accept) begin
            valid_d = 1'b1;
            err_d   = !in_range;
            // An out-of-range word is accepted but leaves code and history alone.
            if (in_range) begin
                code_d = code_next;
                hist_d = hist_new;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            hist_q  <= '0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            hist_q  <= hist_d;
        end
    end

    assign out_code  = code_q;
    assign out_valid = valid_q;
    assign out_err   = err_q;

`ifdef TNS_ENC_ERRCNT_EN
    logic [15:0] err_cnt_d, err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !in_range && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tns_encoder_param.sv
// Directed self-checking bench for tns_encoder_param with NGROUPS=2.
module tb_tns_encoder_param;

    logic       clock;
    logic       reset_n;
    logic [4:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic       out_err;
`ifdef TNS_ENC_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int n_checks;
    int n_fails;

    tns_encoder_param #(
        .NGROUPS(2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef TNS_ENC_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .out_err   (out_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [4:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Reference digit map taken straight from the code table.
    function automatic logic [2:0] enc_digit(input int unsigned d, input logic h);
        case (d)
            0:       return 3'b000;
            1:       return 3'b010;
            2:       return h ? 3'b100 : 3'b011;
            3:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic int unsigned dec_group(input logic [2:0] c);
        case (c)
            3'b000:         return 0;
            3'b010:         return 1;
            3'b011, 3'b100: return 2;
            3'b110:         return 3;
            3'b111:         return 4;
            default:        return 7;
        endcase
    endfunction

    initial begin
        logic [1:0] hist_m;
        logic [5:0] exp_code;
        n_checks = 0;
        n_fails  = 0;

        // 1: reset state and first word
        do_reset();
        check_eq("rst_code", 32'(out_code), 32'(6'b000_000));
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_err", 32'(out_err), 0);
        check_eq("rst_in_ready", 32'(in_ready), 1);
`ifdef TNS_ENC_ERRCNT_EN
        check_eq("rst_err_cnt", 32'(err_cnt), 0);
`endif
        push(5'd12);
        check_eq("t1_code", 32'(out_code), 32'(6'b011_011));
        check_eq("t1_valid", 32'(out_valid), 1);
        check_eq("t1_err", 32'(out_err), 0);

        // 2: back-to-back 22 then 12
        in_data  = 5'd22;
        in_valid = 1'b1;
        tick();
        check_eq("t2_code22", 32'(out_code), 32'(6'b111_011));
        in_data = 5'd12;
        tick();
        check_eq("t2_code12", 32'(out_code), 32'(6'b100_011));
        check_eq("t2_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        tick();
        check_eq("t2_drain", 32'(out_valid), 0);

        // 3: stall with 24 in the register, competing word must not enter
        out_ready = 1'b0;
        push(5'd24);
        check_eq("t3_code", 32'(out_code), 32'(6'b111_111));
        check_eq("t3_in_ready", 32'(in_ready), 0);
        in_data  = 5'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t3_hold_code", 32'(out_code), 32'(6'b111_111));
            check_eq("t3_hold_valid", 32'(out_valid), 1);
            check_eq("t3_hold_rdy", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("t3_release", 32'(out_valid), 0);
        // History from 24 is {1,1}, so 12 resolves both groups high.
        push(5'd12);
        check_eq("t3_hist", 32'(out_code), 32'(6'b100_100));

        // 4: out-of-range word
        do_reset();
        push(5'd12);
        check_eq("t4_pre", 32'(out_code), 32'(6'b011_011));
        push(5'd25);
        check_eq("t4_err", 32'(out_err), 1);
        check_eq("t4_err_valid", 32'(out_valid), 1);
        check_eq("t4_err_code", 32'(out_code), 32'(6'b011_011));
`ifdef TNS_ENC_ERRCNT_EN
        check_eq("t4_err_cnt", 32'(err_cnt), 1);
`endif
        push(5'd12);
        check_eq("t4_post_code", 32'(out_code), 32'(6'b011_011));
        check_eq("t4_post_err", 32'(out_err), 0);
        push(5'd31);
        check_eq("t4_err31", 32'(out_err), 1);
`ifdef TNS_ENC_ERRCNT_EN
        check_eq("t4_err_cnt2", 32'(err_cnt), 2);
`endif

        // 5: sweep 0..24 from reset against the digit-map model
        do_reset();
        hist_m   = 2'b00;
        in_valid = 1'b1;
        for (int v = 0; v < 25; v++) begin
            in_data = 5'(v);
            tick();
            exp_code = {enc_digit(v / 5, hist_m[1]), enc_digit(v % 5, hist_m[0])};
            hist_m   = {exp_code[5], exp_code[2]};
            check_eq("t5_code", 32'(out_code), 32'(exp_code));
            check_eq("t5_roundtrip", dec_group(out_code[5:3]) * 5 + dec_group(out_code[2:0]),
                     v);
        end
        in_valid = 1'b0;

        // 6: reset while stalled
        do_reset();
        out_ready = 1'b0;
        push(5'd24);
        check_eq("t6_pre_valid", 32'(out_valid), 1);
        reset_n = 1'b0;
        #1;
        check_eq("t6_async_valid", 32'(out_valid), 0);
        check_eq("t6_async_code", 32'(out_code), 0);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        push(5'd2);
        check_eq("t6_code", 32'(out_code), 32'(6'b000_011));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
